// File: rtl/gpmc_csr_bank.sv
// GPMC-side CSR bank: ID, scratch registers and N_CHAN identical channel windows
// (sticky UF/OF flags, level readback, control + strobe, saturating error count).

module gpmc_csr_chan #(
  parameter int                AW  = 16,
  parameter int                DW  = 16,
  parameter int                CW  = 13,
  parameter logic [AW-1:0]     WIN = '0
) (
  input  logic          gpmc_clk,
  input  logic          reset_n,
  input  logic [AW-1:0] address,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          uf,
  input  logic          of,
  input  logic [CW-1:0] level,
  output logic [DW-1:0] rd_val,
  output logic [DW-1:0] ctrl,
  output logic          pulse,
  output logic [1:0]    sticky
);
  localparam logic [AW-1:0] A_STS = WIN;
  localparam logic [AW-1:0] A_LVL = WIN + AW'(2);
  localparam logic [AW-1:0] A_CTL = WIN + AW'(4);
  localparam logic [AW-1:0] A_ERR = WIN + AW'(6);

  logic          wr_sts, wr_ctl, wr_err;
  logic [DW-1:0] errcnt, cnt_base;
  logic [1:0]    inc;
  logic [DW:0]   cnt_sum;

  assign wr_sts = wr_en && (address == A_STS);
  assign wr_ctl = wr_en && (address == A_CTL);
  assign wr_err = wr_en && (address == A_ERR);

  // A clear in the same cycle as events leaves exactly that cycle's event count.
  assign inc      = {1'b0, uf} + {1'b0, of};
  assign cnt_base = wr_err ? '0 : errcnt;
  assign cnt_sum  = {1'b0, cnt_base} + (DW+1)'(inc);

  always_ff @(posedge gpmc_clk) begin
    if (!reset_n) begin
      sticky <= '0;
      errcnt <= '0;
      ctrl   <= '0;
      pulse  <= 1'b0;
    end else begin
      // Set wins over W1C so an event is never lost.
      sticky[0] <= uf | (sticky[0] & ~(wr_sts & wr_data[0]));
      sticky[1] <= of | (sticky[1] & ~(wr_sts & wr_data[1]));
      errcnt    <= cnt_sum[DW] ? '1 : cnt_sum[DW-1:0];
      pulse     <= wr_ctl & wr_data[0];
      if (wr_ctl) ctrl <= {wr_data[DW-1:1], 1'b0};
    end
  end

  always_comb begin
    rd_val = '0;
    if (address == A_STS) rd_val = DW'(sticky);
    if (address == A_LVL) rd_val = DW'(level);
    if (address == A_CTL) rd_val = ctrl;
    if (address == A_ERR) rd_val = errcnt;
  end
endmodule

module gpmc_csr_bank #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    N_CHAN       = 2,
  parameter int                    N_SCRATCH    = 2,
  parameter int                    CNT_WIDTH    = 13,
  parameter int                    BASE_ADDR    = 'h0010,
  parameter int                    CHAN_STRIDE  = 'h0010,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE     = 'hC10D,
  parameter logic [DATA_WIDTH-1:0] SCRATCH_INIT = 'h1234
) (
  input  logic                           gpmc_clk,
  input  logic                           reset_n,
  input  logic                           address_valid,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic                           wr_en,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic [DATA_WIDTH-1:0]          rd_data,
  input  logic [N_CHAN-1:0]              ch_underflow,
  input  logic [N_CHAN-1:0]              ch_overflow,
  input  logic [N_CHAN*CNT_WIDTH-1:0]    ch_level,
  output logic [N_CHAN*DATA_WIDTH-1:0]   ch_ctrl,
  output logic [N_CHAN-1:0]              ch_pulse,
  output logic                           irq
);
  if (N_CHAN < 1 || N_CHAN > 8 || N_SCRATCH < 1 || N_SCRATCH > 6 ||
      CNT_WIDTH > DATA_WIDTH || BASE_ADDR < 4 + 2*N_SCRATCH || CHAN_STRIDE < 8) begin : g_param_err
    $error("gpmc_csr_bank: overlapping or out-of-range register map parameters");
  end

  logic [N_SCRATCH-1:0][DATA_WIDTH-1:0] scratch;
  logic [N_CHAN-1:0][DATA_WIDTH-1:0]    ch_rd;
  logic [N_CHAN-1:0][1:0]               ch_sticky;
  logic [N_CHAN-1:0]                    summary;
  logic [DATA_WIDTH-1:0]                rd_next;

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    localparam logic [ADDR_WIDTH-1:0] WIN = ADDR_WIDTH'(BASE_ADDR + c*CHAN_STRIDE);
    gpmc_csr_chan #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .CW(CNT_WIDTH), .WIN(WIN)) u_chan (
      .gpmc_clk (gpmc_clk),
      .reset_n  (reset_n),
      .address  (address),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .uf       (ch_underflow[c]),
      .of       (ch_overflow[c]),
      .level    (ch_level[c*CNT_WIDTH +: CNT_WIDTH]),
      .rd_val   (ch_rd[c]),
      .ctrl     (ch_ctrl[c*DATA_WIDTH +: DATA_WIDTH]),
      .pulse    (ch_pulse[c]),
      .sticky   (ch_sticky[c])
    );
    assign summary[c] = |ch_sticky[c];
  end

  always_ff @(posedge gpmc_clk) begin
    if (!reset_n) begin
      scratch <= {N_SCRATCH{SCRATCH_INIT}};
    end else if (wr_en) begin
      for (int i = 0; i < N_SCRATCH; i++)
        if (address == ADDR_WIDTH'(4 + 2*i)) scratch[i] <= wr_data;
    end
  end

  // Windows never overlap, so per-channel read values can simply be OR-ed.
  always_comb begin
    rd_next = '0;
    if (address == '0)            rd_next = ID_VALUE;
    if (address == ADDR_WIDTH'(2)) rd_next = DATA_WIDTH'(summary);
    for (int i = 0; i < N_SCRATCH; i++)
      if (address == ADDR_WIDTH'(4 + 2*i)) rd_next = scratch[i];
    for (int c = 0; c < N_CHAN; c++)
      rd_next = rd_next | ch_rd[c];
  end

  always_ff @(posedge gpmc_clk) begin
    if (!reset_n) begin
      rd_data <= '0;
      irq     <= 1'b0;
    end else begin
      rd_data <= address_valid ? rd_next : '0;
      irq     <= |summary;
    end
  end
endmodule

// File: tb/tb_gpmc_csr_bank.sv
// Directed self-checking bench for gpmc_csr_bank with default parameters.

module tb_gpmc_csr_bank;
  logic        gpmc_clk = 1'b0;
  logic        reset_n;
  logic        address_valid;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [1:0]  ch_underflow, ch_overflow;
  logic [25:0] ch_level;
  logic [31:0] ch_ctrl;
  logic [1:0]  ch_pulse;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 gpmc_clk = ~gpmc_clk;

  gpmc_csr_bank dut (
    .gpmc_clk      (gpmc_clk),
    .reset_n       (reset_n),
    .address_valid (address_valid),
    .address       (address),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .ch_underflow  (ch_underflow),
    .ch_overflow   (ch_overflow),
    .ch_level      (ch_level),
    .ch_ctrl       (ch_ctrl),
    .ch_pulse      (ch_pulse),
    .irq           (irq)
  );

  task automatic cyc();
    @(posedge gpmc_clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    wr_en = 1'b1; address = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    address_valid = 1'b1; address = a;
    cyc();
    d = rd_data;
    address_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset_n = 1'b0; address_valid = 1'b1; address = 16'h0;
    cyc(); cyc();
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd got %h exp 0000", rd_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (ch_pulse !== 2'b00 || ch_ctrl !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h/%b exp 0", ch_ctrl, ch_pulse); end
    address_valid = 1'b0; reset_n = 1'b1;
    cyc();
    rd(16'h0, d);
    checks++; if (d !== 16'hC10D) begin errors++; $display("FAIL id got %h exp c10d", d); end
    rd(16'h4, d);
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL scratch_init got %h exp 1234", d); end
    rd(16'h16, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL errcnt_reset got %h exp 0000", d); end
  endtask

  task automatic test_scratch();
    logic [15:0] d;
    wr(16'h4, 16'hBEEF);
    rd(16'h4, d);
    checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL scratch0 got %h exp beef", d); end
    rd(16'h6, d);
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL scratch1 got %h exp 1234", d); end
    rd(16'h8, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL unmapped got %h exp 0000", d); end
    rd(16'h5, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL odd_addr got %h exp 0000", d); end
    address = 16'h4; address_valid = 1'b0;
    cyc();
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL no_valid got %h exp 0000", rd_data); end
    wr(16'h0, 16'h5555);
    rd(16'h0, d);
    checks++; if (d !== 16'hC10D) begin errors++; $display("FAIL id_ro got %h exp c10d", d); end
  endtask

  task automatic test_sticky();
    logic [15:0] d;
    ch_underflow = 2'b10;
    cyc();
    ch_underflow = 2'b00;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
    cyc();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
    rd(16'h20, d);
    checks++; if (d !== 16'h1) begin errors++; $display("FAIL status1 got %h exp 0001", d); end
    rd(16'h2, d);
    checks++; if (d !== 16'h2) begin errors++; $display("FAIL summary got %h exp 0002", d); end
    rd(16'h26, d);
    checks++; if (d !== 16'h1) begin errors++; $display("FAIL errcnt1 got %h exp 0001", d); end
    wr(16'h20, 16'h1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b exp 1", irq); end
    cyc();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
    rd(16'h20, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL status1_clr got %h exp 0000", d); end
  endtask

  task automatic test_w1c_race();
    logic [15:0] d;
    wr_en = 1'b1; address = 16'h10; wr_data = 16'h2; ch_overflow = 2'b01;
    cyc();
    wr_en = 1'b0; ch_overflow = 2'b00;
    rd(16'h10, d);
    checks++; if (d !== 16'h2) begin errors++; $display("FAIL w1c_race got %h exp 0002", d); end
    rd(16'h16, d);
    checks++; if (d !== 16'h1) begin errors++; $display("FAIL errcnt0 got %h exp 0001", d); end
    ch_underflow = 2'b01;
    cyc();
    ch_underflow = 2'b00;
    wr(16'h10, 16'h0);
    rd(16'h10, d);
    checks++; if (d !== 16'h3) begin errors++; $display("FAIL w0_noeffect got %h exp 0003", d); end
    wr(16'h10, 16'h2);
    rd(16'h10, d);
    checks++; if (d !== 16'h1) begin errors++; $display("FAIL w1c_of got %h exp 0001", d); end
    wr(16'h10, 16'h1);
    rd(16'h10, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL w1c_uf got %h exp 0000", d); end
  endtask

  task automatic test_errcnt();
    logic [15:0] d;
    wr(16'h16, 16'h0);
    rd(16'h16, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL errcnt_clr got %h exp 0000", d); end
    wr_en = 1'b1; address = 16'h16; wr_data = 16'h0; ch_underflow = 2'b01; ch_overflow = 2'b01;
    cyc();
    wr_en = 1'b0; ch_overflow = 2'b00; ch_underflow = 2'b00;
    rd(16'h16, d);
    checks++; if (d !== 16'h2) begin errors++; $display("FAIL errcnt_clr_evt got %h exp 0002", d); end
    wr_en = 1'b1; address = 16'h16; ch_underflow = 2'b01;
    cyc();
    wr_en = 1'b0; ch_underflow = 2'b00;
    ch_underflow = 2'b01; ch_overflow = 2'b01;
    cyc();
    ch_underflow = 2'b00; ch_overflow = 2'b00;
    rd(16'h16, d);
    checks++; if (d !== 16'h3) begin errors++; $display("FAIL errcnt_plus2 got %h exp 0003", d); end
    ch_underflow = 2'b01; ch_overflow = 2'b01;
    repeat (32766) cyc();
    ch_underflow = 2'b00; ch_overflow = 2'b00;
    rd(16'h16, d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL errcnt_full got %h exp ffff", d); end
    ch_underflow = 2'b01; ch_overflow = 2'b01;
    repeat (5) cyc();
    ch_underflow = 2'b00; ch_overflow = 2'b00;
    rd(16'h16, d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL errcnt_sat got %h exp ffff", d); end
    rd(16'h26, d);
    checks++; if (d !== 16'h1) begin errors++; $display("FAIL errcnt_ch1 got %h exp 0001", d); end
    wr(16'h10, 16'h3);
    cyc();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clr got %b exp 0", irq); end
  endtask

  task automatic test_ctrl();
    logic [15:0] d;
    wr(16'h14, 16'h0103);
    checks++; if (ch_pulse !== 2'b01) begin errors++; $display("FAIL pulse0 got %b exp 01", ch_pulse); end
    checks++; if (ch_ctrl[15:0] !== 16'h0102) begin errors++; $display("FAIL ctrl0 got %h exp 0102", ch_ctrl[15:0]); end
    cyc();
    checks++; if (ch_pulse !== 2'b00) begin errors++; $display("FAIL pulse0_width got %b exp 00", ch_pulse); end
    rd(16'h14, d);
    checks++; if (d !== 16'h0102) begin errors++; $display("FAIL ctrl0_rd got %h exp 0102", d); end
    wr_en = 1'b1; address = 16'h24; wr_data = 16'h0001;
    cyc();
    checks++; if (ch_pulse !== 2'b10) begin errors++; $display("FAIL b2b_pulse1 got %b exp 10", ch_pulse); end
    wr_data = 16'h8001;
    cyc();
    wr_en = 1'b0;
    checks++; if (ch_pulse !== 2'b10) begin errors++; $display("FAIL b2b_pulse2 got %b exp 10", ch_pulse); end
    cyc();
    checks++; if (ch_pulse !== 2'b00) begin errors++; $display("FAIL b2b_end got %b exp 00", ch_pulse); end
    checks++; if (ch_ctrl !== 32'h8000_0102) begin errors++; $display("FAIL ctrl_all got %h exp 80000102", ch_ctrl); end
    wr(16'h14, 16'h00F0);
    checks++; if (ch_pulse !== 2'b00 || ch_ctrl[15:0] !== 16'h00F0) begin errors++; $display("FAIL ctrl_nopulse got %b/%h exp 00/00f0", ch_pulse, ch_ctrl[15:0]); end
  endtask

  task automatic test_level();
    logic [15:0] d;
    ch_level = {13'h1ABC, 13'h0FFF};
    rd(16'h12, d);
    checks++; if (d !== 16'h0FFF) begin errors++; $display("FAIL level0 got %h exp 0fff", d); end
    rd(16'h22, d);
    checks++; if (d !== 16'h1ABC) begin errors++; $display("FAIL level1 got %h exp 1abc", d); end
    wr(16'h22, 16'hFFFF);
    rd(16'h22, d);
    checks++; if (d !== 16'h1ABC) begin errors++; $display("FAIL level_ro got %h exp 1abc", d); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] d;
    reset_n = 1'b0; wr_en = 1'b1; address = 16'h6; wr_data = 16'hAAAA; ch_underflow = 2'b01;
    cyc();
    wr_en = 1'b0; ch_underflow = 2'b00; reset_n = 1'b1;
    rd(16'h6, d);
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL rst_write_drop got %h exp 1234", d); end
    rd(16'h10, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL rst_event_drop got %h exp 0000", d); end
    rd(16'h14, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL rst_ctrl got %h exp 0000", d); end
    rd(16'h4, d);
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL rst_scratch got %h exp 1234", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
  endtask

  initial begin
    reset_n = 1'b0; address_valid = 1'b0; address = '0; wr_en = 1'b0; wr_data = '0;
    ch_underflow = '0; ch_overflow = '0; ch_level = '0;
    test_reset();
    test_scratch();
    test_sticky();
    test_w1c_race();
    test_errcnt();
    test_ctrl();
    test_level();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
